// File: rtl/scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scan_ctrl_pkg
//   Shared types and constants for the scan test controller.
//   - scan_state_e      : controller FSM states
//   - NBART_SHIFT/FUNC  : encodings of the chain NbarT pin (1 = shift, 0 = functional)
//   - MISR_POLY_DEFAULT : default feedback polynomial for the optional signature MISR
// -----------------------------------------------------------------------------
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        WAIT,
        DRAIN,
        RESP
    } scan_state_e;

    localparam logic NBART_SHIFT = 1'b1;
    localparam logic NBART_FUNC  = 1'b0;

    localparam logic [15:0] MISR_POLY_DEFAULT = 16'h1021;

endpackage

// File: rtl/scan_test_controller_if.sv
// -----------------------------------------------------------------------------
// scan_test_controller_if
//   Pattern / response handshake bundle between the stimulus source and the
//   scan test controller.
//   Signals:
//     pat_valid, pat_ready, pat_data[CHAIN_LEN], pat_last : pattern channel
//     rsp_valid, rsp_ready, rsp_data[CHAIN_LEN]           : response channel
//   Modports:
//     master : stimulus source / response consumer
//     slave  : the controller
// -----------------------------------------------------------------------------
interface scan_test_controller_if #(
    parameter int CHAIN_LEN = 17
);
    logic                 pat_valid;
    logic                 pat_ready;
    logic [CHAIN_LEN-1:0] pat_data;
    logic                 pat_last;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CHAIN_LEN-1:0] rsp_data;

    modport master (
        output pat_valid, pat_data, pat_last, rsp_ready,
        input  pat_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  pat_valid, pat_data, pat_last, rsp_ready,
        output pat_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/scan_misr.sv
// -----------------------------------------------------------------------------
// scan_misr
//   Serial-input signature register (Galois form). Each enabled cycle the
//   register shifts left by one; when the MSB xor the incoming bit is 1 the
//   polynomial is folded in, so the input bit enters through POLY[0].
//   Ports:
//     clk  in            clock
//     rst  in            synchronous active-high reset (clears signature)
//     clr  in            synchronous clear (start of a new run)
//     en   in            fold din into the signature this cycle
//     din  in            serial data bit
//     sig  out [MISR_W]  current signature
// -----------------------------------------------------------------------------
module scan_misr #(
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_reg;
    logic [MISR_W-1:0] step_val;
    logic              feedback;

    assign feedback = sig_reg[MISR_W-1] ^ din;

    for (genvar gi = 0; gi < MISR_W; gi++) begin : g_bit
        if (gi == 0) begin : g_lsb
            assign step_val[gi] = MISR_POLY[gi] & feedback;
        end else begin : g_upper
            assign step_val[gi] = sig_reg[gi-1] ^ (MISR_POLY[gi] & feedback);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig_reg <= '0;
        end else if (en) begin
            sig_reg <= step_val;
        end
    end

    assign sig = sig_reg;

endmodule

// File: rtl/scan_test_controller.sv
// -----------------------------------------------------------------------------
// scan_test_controller
//   Sequences scan test of a CHAIN_LEN-flop scan chain: accepts parallel
//   patterns, shifts them in serially (bit0 first), issues one functional
//   capture cycle, and unloads the captured response while the next pattern
//   shifts in. The final response is unloaded by a drain pass.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     bus (slave)       pattern / response handshake (scan_test_controller_if)
//     nbar_t            chain NbarT (1 = shift, 0 = functional)
//     chain_ce          chain clock enable
//     si / so           serial data into / out of the chain
//     pat_cnt           captures since reset (wraps)
//     busy              controller not idle
//     done              one-cycle pulse at the end of a run
//     sig_valid,
//     signature         (SCAN_MISR_EN only) run signature and its valid level
//
//   Build option: define SCAN_MISR_EN to compress the unloaded stream into a
//   MISR instead of returning per-pattern responses on rsp_*.
// -----------------------------------------------------------------------------
module scan_test_controller
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 17,
    parameter int CNT_W     = 16
`ifdef SCAN_MISR_EN
    ,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(MISR_POLY_DEFAULT)
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    scan_test_controller_if.slave        bus,
    output logic                         nbar_t,
    output logic                         chain_ce,
    output logic                         si,
    input  logic                         so,
    output logic [CNT_W-1:0]             pat_cnt,
    output logic                         busy,
    output logic                         done
`ifdef SCAN_MISR_EN
    ,
    output logic                         sig_valid,
    output logic [MISR_W-1:0]            signature
`endif
);

    localparam int              BIT_W    = $clog2(CHAIN_LEN);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);

    scan_state_e          state_reg, state_next;
    logic [CHAIN_LEN-1:0] shreg_reg, shreg_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [CNT_W-1:0]     pat_cnt_reg, pat_cnt_next;
    logic                 have_rsp_reg, have_rsp_next;
    logic                 last_q_reg, last_q_next;
    // Remembers whether RESP was entered after a drain (run ends) or after
    // an overlapped shift (a capture of the new pattern is still owed).
    logic                 from_drain_reg, from_drain_next;
    logic                 done_reg, done_next;

    logic                 pat_ready_c;
    logic                 nbar_t_c;
    logic                 chain_ce_c;
    logic                 si_c;

`ifdef SCAN_MISR_EN
    logic                 sig_valid_reg, sig_valid_next;
    logic                 misr_clr;
    logic                 misr_en;
`else
    logic                 rsp_valid_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            shreg_reg      <= '0;
            bit_cnt_reg    <= '0;
            pat_cnt_reg    <= '0;
            have_rsp_reg   <= 1'b0;
            last_q_reg     <= 1'b0;
            from_drain_reg <= 1'b0;
            done_reg       <= 1'b0;
`ifdef SCAN_MISR_EN
            sig_valid_reg  <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            bit_cnt_reg    <= bit_cnt_next;
            pat_cnt_reg    <= pat_cnt_next;
            have_rsp_reg   <= have_rsp_next;
            last_q_reg     <= last_q_next;
            from_drain_reg <= from_drain_next;
            done_reg       <= done_next;
`ifdef SCAN_MISR_EN
            sig_valid_reg  <= sig_valid_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        shreg_next      = shreg_reg;
        bit_cnt_next    = bit_cnt_reg;
        pat_cnt_next    = pat_cnt_reg;
        have_rsp_next   = have_rsp_reg;
        last_q_next     = last_q_reg;
        from_drain_next = from_drain_reg;
        done_next       = 1'b0;
        pat_ready_c     = 1'b0;
        nbar_t_c        = NBART_FUNC;
        chain_ce_c      = 1'b0;
        si_c            = 1'b0;
`ifdef SCAN_MISR_EN
        sig_valid_next  = sig_valid_reg;
        misr_clr        = 1'b0;
        misr_en         = 1'b0;
`else
        rsp_valid_c     = 1'b0;
`endif

        case (state_reg)
            IDLE, WAIT: begin
                pat_ready_c = 1'b1;
                if (bus.pat_valid) begin
                    shreg_next   = bus.pat_data;
                    last_q_next  = bus.pat_last;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
`ifdef SCAN_MISR_EN
                    sig_valid_next = 1'b0;
                    // Only the first pattern of a run starts a fresh signature.
                    misr_clr       = (state_reg == IDLE);
`endif
                end
            end

            SHIFT, DRAIN: begin
                nbar_t_c     = NBART_SHIFT;
                chain_ce_c   = 1'b1;
                si_c         = (state_reg == SHIFT) ? shreg_reg[0] : 1'b0;
                // so is the chain output before this edge, i.e. the bit
                // being displaced by si; it enters shreg from the top so the
                // first unloaded bit ends up in bit0.
                shreg_next   = {so, shreg_reg[CHAIN_LEN-1:1]};
                bit_cnt_next = bit_cnt_reg + 1'b1;
`ifdef SCAN_MISR_EN
                misr_en      = have_rsp_reg;
`endif
                if (bit_cnt_reg == LAST_BIT) begin
                    bit_cnt_next = '0;
`ifdef SCAN_MISR_EN
                    have_rsp_next = 1'b0;
                    if (state_reg == SHIFT) begin
                        state_next = CAPTURE;
                    end else begin
                        state_next     = IDLE;
                        done_next      = 1'b1;
                        sig_valid_next = 1'b1;
                    end
`else
                    if (have_rsp_reg) begin
                        state_next      = RESP;
                        from_drain_next = (state_reg == DRAIN);
                    end else if (state_reg == SHIFT) begin
                        state_next = CAPTURE;
                    end else begin
                        state_next = IDLE;
                    end
`endif
                end
            end

            CAPTURE: begin
                nbar_t_c      = NBART_FUNC;
                chain_ce_c    = 1'b1;
                pat_cnt_next  = pat_cnt_reg + 1'b1;
                have_rsp_next = 1'b1;
                bit_cnt_next  = '0;
                state_next    = last_q_reg ? DRAIN : WAIT;
            end

            RESP: begin
                // Chain is frozen here: the next pattern already sits in it.
`ifndef SCAN_MISR_EN
                rsp_valid_c = 1'b1;
`endif
                if (bus.rsp_ready) begin
                    have_rsp_next = 1'b0;
                    if (from_drain_reg) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = CAPTURE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control outputs are forced low while rst is high so the chain stops
    // in the very cycle reset is asserted.
    assign bus.pat_ready = pat_ready_c & ~rst;
    assign nbar_t        = nbar_t_c & ~rst;
    assign chain_ce      = chain_ce_c & ~rst;
    assign si            = si_c & ~rst;
    assign busy          = (state_reg != IDLE) & ~rst;
    assign done          = done_reg & ~rst;
    assign pat_cnt       = pat_cnt_reg;

`ifdef SCAN_MISR_EN
    assign bus.rsp_valid = 1'b0;
    assign bus.rsp_data  = '0;
    assign sig_valid     = sig_valid_reg & ~rst;

    scan_misr #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (misr_clr),
        .en  (misr_en),
        .din (so),
        .sig (signature)
    );
`else
    assign bus.rsp_valid = rsp_valid_c & ~rst;
    assign bus.rsp_data  = shreg_reg;
`endif

endmodule
